dsp7_capture: RTL

//  Receive-side companion of the BCD->7-segment decoder. Samples a time-multiplexed,

---
 rtl/dsp7_capture.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/dsp7_capture.sv
// Samples a multiplexed active-low 7-segment bus, waits for each digit to settle,
// then decodes it back to BCD per anode position. Capture lands STABLE+1 edges after the pattern appears.
module dsp7_capture #(
  parameter int NDIG   = 4,
  parameter int STABLE = 4,
  parameter int CW     = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [6:0]        seg,
  input  logic [NDIG-1:0]   an,
  output logic [4*NDIG-1:0] digits,
  output logic [NDIG-1:0]   valid,
  output logic [NDIG-1:0]   err,
  output logic              frame
);

  localparam int IW  = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int NZW = $clog2(NDIG + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t          state;
  logic [NDIG-1:0] s_an, r_an, seen;
  logic [6:0]      s_seg, r_seg;
  logic [CW-1:0]   cnt;

  logic [NZW-1:0]  nzero;
  logic [IW-1:0]   sel;
  logic            legal, same, cap, dec_ok, dec_blank;
  logic [3:0]      dec_val;
  logic [NDIG-1:0] seen_next;

  always_comb begin
    nzero = '0;
    sel   = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (!s_an[i]) begin
        nzero = nzero + 1'b1;
        sel   = i[IW-1:0];
      end
    end
  end

  assign legal     = (nzero == NZW'(1));
  assign same      = (s_an == r_an) && (s_seg == r_seg);
  assign cap       = (state == SETTLE) && legal && same && (cnt == CNT_LAST);
  assign dec_blank = (s_seg == 7'h7F);
  assign seen_next = seen | ({{(NDIG-1){1'b0}}, 1'b1} << sel);

  // Patterns are gfedcba with segments lit on 0.
  always_comb begin
    dec_ok  = 1'b1;
    dec_val = 4'd0;
    case (s_seg)
      7'h40: dec_val = 4'd0;
      7'h79: dec_val = 4'd1;
      7'h24: dec_val = 4'd2;
      7'h30: dec_val = 4'd3;
      7'h19: dec_val = 4'd4;
      7'h12: dec_val = 4'd5;
      7'h02: dec_val = 4'd6;
      7'h78: dec_val = 4'd7;
      7'h00: dec_val = 4'd8;
      7'h18: dec_val = 4'd9;
      default: dec_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      s_an   <= '1;
      s_seg  <= 7'h7F;
      r_an   <= '1;
      r_seg  <= 7'h7F;
      cnt    <= '0;
      seen   <= '0;
      digits <= '0;
      valid  <= '0;
      err    <= '0;
      frame  <= 1'b0;
    end else begin
      s_an  <= an;
      s_seg <= seg;
      frame <= 1'b0;

      case (state)
        IDLE: begin
          if (legal) begin
            state <= SETTLE;
            cnt   <= CW'(1);
            r_an  <= s_an;
            r_seg <= s_seg;
          end
        end
        SETTLE: begin
          if (legal && same) begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) state <= HOLD;
          end else if (legal) begin
            cnt   <= CW'(1);
            r_an  <= s_an;
            r_seg <= s_seg;
          end else begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          // HOLD: counter stays saturated until the bus changes.
          if (!same) begin
            if (legal) begin
              state <= SETTLE;
              cnt   <= CW'(1);
              r_an  <= s_an;
              r_seg <= s_seg;
            end else begin
              state <= IDLE;
              cnt   <= '0;
            end
          end
        end
      endcase

      if (cap) begin
        if (dec_ok) digits[4*int'(sel) +: 4] <= dec_val;
        valid[sel] <= dec_ok;
        err[sel]   <= !dec_ok && !dec_blank;
        if (&seen_next) begin
          frame <= 1'b1;
          seen  <= '0;
        end else begin
          seen  <= seen_next;
        end
      end
    end
  end

endmodule
